// File: rtl/key_entry_buffer.sv
// Numeric entry buffer: turns PS/2 make events into BCD digits shifted into a
// DIGITS-wide display buffer, with backspace, clear, enter/commit and repeat filtering.
module key_entry_buffer #(
  parameter int         DIGITS    = 4,
  parameter logic [3:0] BLANK     = 4'hF,
  parameter bit         OVF_SHIFT = 1'b1,
  parameter bit         REPEAT_EN = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [8:0]          last_change,
  input  logic                key_is_down,
  output logic [4*DIGITS-1:0] digits,
  output logic [3:0]          count,
  output logic [4*DIGITS-1:0] value,
  output logic                commit,
  output logic                overflow
);

  localparam int                W         = 4 * DIGITS;
  localparam logic [3:0]        CNT_MAX   = 4'(DIGITS);
  localparam logic [W-1:0]      ALL_BLANK = {DIGITS{BLANK}};

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ENTRY = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [2:0] K_NONE  = 3'd0;
  localparam logic [2:0] K_DIGIT = 3'd1;
  localparam logic [2:0] K_BKSP  = 3'd2;
  localparam logic [2:0] K_ESC   = 3'd3;
  localparam logic [2:0] K_ENTER = 3'd4;

  logic [1:0]   state;
  logic [8:0]   held;
  logic         held_vld;

  logic [2:0]   kind;
  logic [3:0]   dval;
  logic         make_ok;

  logic [1:0]   state_n;
  logic [W-1:0] digits_n;
  logic [W-1:0] value_n;
  logic [3:0]   count_n;
  logic         commit_n;
  logic         overflow_n;
  logic [8:0]   held_n;
  logic         held_vld_n;

  // New digit enters at nibble 0; the oldest falls off the top.
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] v, input logic [3:0] d);
    logic [W+3:0] t;
    t = {v, d};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] shift_out(input logic [W-1:0] v);
    logic [W+3:0] t;
    t = {BLANK, v};
    return t[W+3:4];
  endfunction

  always_comb begin
    kind = K_NONE;
    dval = 4'd0;
    case (last_change)
      9'h045, 9'h070: begin kind = K_DIGIT; dval = 4'd0; end
      9'h016, 9'h069: begin kind = K_DIGIT; dval = 4'd1; end
      9'h01E, 9'h072: begin kind = K_DIGIT; dval = 4'd2; end
      9'h026, 9'h07A: begin kind = K_DIGIT; dval = 4'd3; end
      9'h025, 9'h06B: begin kind = K_DIGIT; dval = 4'd4; end
      9'h02E, 9'h073: begin kind = K_DIGIT; dval = 4'd5; end
      9'h036, 9'h074: begin kind = K_DIGIT; dval = 4'd6; end
      9'h03D, 9'h06C: begin kind = K_DIGIT; dval = 4'd7; end
      9'h03E, 9'h075: begin kind = K_DIGIT; dval = 4'd8; end
      9'h046, 9'h07D: begin kind = K_DIGIT; dval = 4'd9; end
      9'h066:         kind = K_BKSP;
      9'h076:         kind = K_ESC;
      9'h05A, 9'h15A: kind = K_ENTER;
      default:        kind = K_NONE;
    endcase
  end

  assign make_ok = key_valid && key_is_down &&
                   (REPEAT_EN || !(held_vld && (held == last_change)));

  always_comb begin
    state_n    = state;
    digits_n   = digits;
    value_n    = value;
    count_n    = count;
    commit_n   = 1'b0;
    overflow_n = 1'b0;
    held_n     = held;
    held_vld_n = held_vld;

    if (key_valid && !key_is_down && held_vld && (held == last_change))
      held_vld_n = 1'b0;

    if (make_ok) begin
      held_n     = last_change;
      held_vld_n = 1'b1;
      case (kind)
        K_DIGIT: begin
          if (state != ST_FULL) begin
            digits_n = shift_in(digits, dval);
            count_n  = count + 4'd1;
            state_n  = (count + 4'd1 == CNT_MAX) ? ST_FULL : ST_ENTRY;
          end else begin
            overflow_n = 1'b1;
            if (OVF_SHIFT) digits_n = shift_in(digits, dval);
          end
        end
        K_BKSP: begin
          if (state != ST_EMPTY) begin
            digits_n = shift_out(digits);
            count_n  = count - 4'd1;
            state_n  = (count == 4'd1) ? ST_EMPTY : ST_ENTRY;
          end
        end
        K_ESC: begin
          digits_n = ALL_BLANK;
          count_n  = 4'd0;
          state_n  = ST_EMPTY;
        end
        K_ENTER: begin
          if (state != ST_EMPTY) begin
            value_n  = digits;
            commit_n = 1'b1;
            digits_n = ALL_BLANK;
            count_n  = 4'd0;
            state_n  = ST_EMPTY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      digits   <= ALL_BLANK;
      value    <= ALL_BLANK;
      count    <= 4'd0;
      commit   <= 1'b0;
      overflow <= 1'b0;
      held     <= 9'd0;
      held_vld <= 1'b0;
    end else begin
      state    <= state_n;
      digits   <= digits_n;
      value    <= value_n;
      count    <= count_n;
      commit   <= commit_n;
      overflow <= overflow_n;
      held     <= held_n;
      held_vld <= held_vld_n;
    end
  end

endmodule

// File: tb/tb_key_entry_buffer.sv
// Bench for key_entry_buffer: three parameter variants share one directed
// stimulus stream and are checked every cycle against a digit-list model.
module tb_key_entry_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [8:0] last_change = 9'd0;
  logic       key_is_down = 1'b0;

  logic [15:0] dg [3];
  logic [3:0]  cn [3];
  logic [15:0] vl [3];
  logic        cm [3];
  logic        ov [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // inst 0: shift on overflow, repeat filtered; inst 1: reject on overflow; inst 2: repeat allowed
  key_entry_buffer #(.DIGITS(4), .BLANK(4'hF), .OVF_SHIFT(1'b1), .REPEAT_EN(1'b0)) dut_a (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
    .key_is_down(key_is_down), .digits(dg[0]), .count(cn[0]), .value(vl[0]),
    .commit(cm[0]), .overflow(ov[0]));
  key_entry_buffer #(.DIGITS(4), .BLANK(4'hF), .OVF_SHIFT(1'b0), .REPEAT_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
    .key_is_down(key_is_down), .digits(dg[1]), .count(cn[1]), .value(vl[1]),
    .commit(cm[1]), .overflow(ov[1]));
  key_entry_buffer #(.DIGITS(4), .BLANK(4'hF), .OVF_SHIFT(1'b1), .REPEAT_EN(1'b1)) dut_c (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
    .key_is_down(key_is_down), .digits(dg[2]), .count(cn[2]), .value(vl[2]),
    .commit(cm[2]), .overflow(ov[2]));

  // Model: entered digits kept oldest-first as a plain list
  bit          m_ovf_shift [3] = '{1'b1, 1'b0, 1'b1};
  bit          m_repeat    [3] = '{1'b0, 1'b0, 1'b1};
  int          ent [3][4];
  int          m_cnt [3];
  logic [15:0] m_val [3];
  bit          m_commit [3];
  bit          m_ovf [3];
  bit          m_held_v [3];
  logic [8:0]  m_held [3];

  int top_codes [10] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
  int kp_codes  [10] = '{'h70, 'h69, 'h72, 'h7A, 'h6B, 'h73, 'h74, 'h6C, 'h75, 'h7D};

  function automatic int key_digit(input logic [8:0] c);
    for (int i = 0; i < 10; i++) begin
      if (int'(c) == top_codes[i] || int'(c) == kp_codes[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [15:0] m_digits(input int k);
    logic [15:0] v;
    v = 16'hFFFF;
    for (int i = 0; i < m_cnt[k]; i++) v[4*i +: 4] = 4'(ent[k][m_cnt[k]-1-i]);
    return v;
  endfunction

  task automatic model_step(input int k, input logic r, input logic v,
                            input logic [8:0] c, input logic dn);
    int d;
    m_commit[k] = 1'b0;
    m_ovf[k]    = 1'b0;
    if (r) begin
      m_cnt[k] = 0; m_val[k] = 16'hFFFF; m_held_v[k] = 1'b0;
    end else if (v && !dn) begin
      if (m_held_v[k] && m_held[k] == c) m_held_v[k] = 1'b0;
    end else if (v && dn && (m_repeat[k] || !(m_held_v[k] && m_held[k] == c))) begin
      m_held[k] = c; m_held_v[k] = 1'b1;
      d = key_digit(c);
      if (d >= 0) begin
        if (m_cnt[k] < 4) begin
          ent[k][m_cnt[k]] = d; m_cnt[k]++;
        end else begin
          m_ovf[k] = 1'b1;
          if (m_ovf_shift[k]) begin
            for (int j = 0; j < 3; j++) ent[k][j] = ent[k][j+1];
            ent[k][3] = d;
          end
        end
      end else if (c == 9'h066) begin
        if (m_cnt[k] > 0) m_cnt[k]--;
      end else if (c == 9'h076) begin
        m_cnt[k] = 0;
      end else if (c == 9'h05A || c == 9'h15A) begin
        if (m_cnt[k] > 0) begin
          m_val[k] = m_digits(k); m_commit[k] = 1'b1; m_cnt[k] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d got=%h expected=%h at %0t", name, k, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model, then compare every instance after the edge
  task automatic tick(input logic r, input logic v, input logic [8:0] c, input logic dn);
    rst = r; key_valid = v; last_change = c; key_is_down = dn;
    for (int k = 0; k < 3; k++) model_step(k, r, v, c, dn);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk("digits",   k, 32'(dg[k]), 32'(m_digits(k)));
      chk("count",    k, 32'(cn[k]), 32'(m_cnt[k]));
      chk("value",    k, 32'(vl[k]), 32'(m_val[k]));
      chk("commit",   k, 32'(cm[k]), 32'(m_commit[k]));
      chk("overflow", k, 32'(ov[k]), 32'(m_ovf[k]));
    end
  endtask

  task automatic idle();                 tick(1'b0, 1'b0, 9'h000, 1'b0); endtask
  task automatic make(input logic [8:0] c); tick(1'b0, 1'b1, c, 1'b1); endtask
  task automatic brk(input logic [8:0] c);  tick(1'b0, 1'b1, c, 1'b0); endtask
  task automatic press(input logic [8:0] c); make(c); brk(c); endtask

  initial begin
    // T1 reset
    tick(1'b1, 1'b0, 9'h000, 1'b0);
    tick(1'b1, 1'b0, 9'h000, 1'b0);
    chk("t1_digits", 0, 32'(dg[0]), 32'h0000FFFF);
    chk("t1_value",  0, 32'(vl[0]), 32'h0000FFFF);
    chk("t1_count",  0, 32'(cn[0]), 32'd0);
    idle();

    // T2 entry and commit
    press(9'h016); press(9'h01E); press(9'h026);
    chk("t2_digits", 0, 32'(dg[0]), 32'h0000F123);
    chk("t2_count",  0, 32'(cn[0]), 32'd3);
    make(9'h05A);
    chk("t2_value",  0, 32'(vl[0]), 32'h0000F123);
    chk("t2_commit", 0, 32'(cm[0]), 32'd1);
    chk("t2_clear",  0, 32'(dg[0]), 32'h0000FFFF);
    brk(9'h05A);
    chk("t2_pulse",  0, 32'(cm[0]), 32'd0);

    // T3 overflow
    press(9'h016); press(9'h01E); press(9'h026); press(9'h025);
    make(9'h02E);
    chk("t3_ovf_a",  0, 32'(ov[0]), 32'd1);
    chk("t3_ovf_b",  1, 32'(ov[1]), 32'd1);
    brk(9'h02E);
    chk("t3_shift",  0, 32'(dg[0]), 32'h00002345);
    chk("t3_reject", 1, 32'(dg[1]), 32'h00001234);
    chk("t3_count",  0, 32'(cn[0]), 32'd4);
    press(9'h076);

    // T4 backspace
    press(9'h016); press(9'h01E); press(9'h026);
    press(9'h066); press(9'h066);
    chk("t4_digits", 0, 32'(dg[0]), 32'h0000FFF1);
    chk("t4_count",  0, 32'(cn[0]), 32'd1);
    press(9'h066); press(9'h066);
    chk("t4_empty",  0, 32'(dg[0]), 32'h0000FFFF);
    chk("t4_cnt0",   0, 32'(cn[0]), 32'd0);

    // T5 repeat filter
    for (int i = 0; i < 5; i++) make(9'h016);
    chk("t5_filt",   0, 32'(dg[0]), 32'h0000FFF1);
    chk("t5_rep",    2, 32'(dg[2]), 32'h00001111);
    brk(9'h016);
    make(9'h016);
    chk("t5_rebrk",  0, 32'(dg[0]), 32'h0000FF11);
    brk(9'h016);
    press(9'h076);

    // Extended-keypad code ignored, keypad digit accepted, E0 enter commits
    press(9'h16C);
    press(9'h06C);
    chk("kp_digit",  0, 32'(dg[0]), 32'h0000FFF7);
    make(9'h15A);
    chk("e0_commit", 0, 32'(cm[0]), 32'd1);
    chk("e0_value",  0, 32'(vl[0]), 32'h0000FFF7);
    brk(9'h15A);

    // T6 enter on empty, then reset over a coincident event
    press(9'h05A); press(9'h15A);
    chk("t6_value",  0, 32'(vl[0]), 32'h0000FFF7);
    press(9'h016); press(9'h01E);
    tick(1'b1, 1'b1, 9'h05A, 1'b1);
    chk("t6_rdig",   0, 32'(dg[0]), 32'h0000FFFF);
    chk("t6_rval",   0, 32'(vl[0]), 32'h0000FFFF);
    chk("t6_rcm",    0, 32'(cm[0]), 32'd0);
    idle(); idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
